// File: rtl/ball_collision_if.sv
// Ball/paddle geometry in, bounce code and scoreboard out: the link between
// the collision referee (slave) and whatever drives the playfield (master).
interface ball_collision_if;
  logic [9:0] ball_x;
  logic [9:0] ball_y;
  logic [7:0] ball_w;
  logic [7:0] ball_h;
  logic [9:0] paddle_l_y;
  logic [9:0] paddle_r_y;
  logic [1:0] bounce;
  logic [3:0] score_l;
  logic [3:0] score_r;
  logic       game_over;

  modport master (
    output ball_x, ball_y, ball_w, ball_h, paddle_l_y, paddle_r_y,
    input  bounce, score_l, score_r, game_over
  );

  modport slave (
    input  ball_x, ball_y, ball_w, ball_h, paddle_l_y, paddle_r_y,
    output bounce, score_l, score_r, game_over
  );
endinterface

// File: rtl/ball_collision.sv
// Pong collision referee: registers ball/paddle geometry, raises a held bounce
// code for the ball FSM, keeps score and latches game-over. Optional macro
// SERVE_PAUSE_EN adds a SERVE_DELAY-clock re-serve pause after each point.
module ball_collision #(
  parameter int SCREEN_X    = 640,
  parameter int SCREEN_Y    = 480,
  parameter int PADDLE_L_X  = 16,
  parameter int PADDLE_R_X  = 618,
  parameter int PADDLE_W    = 6,
  parameter int PADDLE_H    = 48,
  parameter int SCORE_MAX   = 9,
  parameter int SERVE_DELAY = 1000
) (
  input logic             clock,
  input logic             reset,
  ball_collision_if.slave bus
);

  if (SCORE_MAX < 1 || SCORE_MAX > 15) begin : g_bad_score_max
    $error("SCORE_MAX must fit the 4-bit score outputs");
  end
  if (SERVE_DELAY < 1 || SERVE_DELAY > 2047) begin : g_bad_serve_delay
    $error("SERVE_DELAY must fit the 11-bit serve counter");
  end

  typedef enum logic [1:0] {
    B_NONE   = 2'b00,
    B_PADDLE = 2'b01,
    B_WALL   = 2'b10,
    B_SCORE  = 2'b11
  } bounce_e;

  typedef enum logic [1:0] {
    TRACK,
    HOLD,
    GAME_OVER
`ifdef SERVE_PAUSE_EN
    , SERVE
`endif
  } state_e;

  localparam logic [3:0] SCORE_TOP = 4'(SCORE_MAX);

  // Stage R: every detection below looks only at these registered copies.
  logic [9:0] r_x, r_y, r_pl, r_pr;
  logic [7:0] r_w, r_h;
  logic       r_valid;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of every other flop, regardless of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_x     <= '0;
      r_y     <= '0;
      r_w     <= '0;
      r_h     <= '0;
      r_pl    <= '0;
      r_pr    <= '0;
      r_valid <= 1'b0;
    end else begin
      r_x     <= bus.ball_x;
      r_y     <= bus.ball_y;
      r_w     <= bus.ball_w;
      r_h     <= bus.ball_h;
      r_pl    <= bus.paddle_l_y;
      r_pr    <= bus.paddle_r_y;
      r_valid <= 1'b1;
    end
  end

  // Edge sums carry an extra bit so x+w / y+h / paddle+H never wrap.
  logic [10:0] ball_right, ball_bottom, pl_bottom, pr_bottom;
  logic        hit_score_r, hit_score_l, hit_paddle_l, hit_paddle_r, hit_wall;

  always_comb begin
    ball_right   = {1'b0, r_x} + {3'b000, r_w};
    ball_bottom  = {1'b0, r_y} + {3'b000, r_h};
    pl_bottom    = {1'b0, r_pl} + 11'(PADDLE_H);
    pr_bottom    = {1'b0, r_pr} + 11'(PADDLE_H);
    hit_score_r  = (r_x == 10'd0);
    hit_score_l  = (ball_right >= 11'(SCREEN_X));
    hit_paddle_l = ({1'b0, r_x} == 11'(PADDLE_L_X + PADDLE_W)) &&
                   (ball_bottom > {1'b0, r_pl}) && ({1'b0, r_y} < pl_bottom);
    hit_paddle_r = (ball_right == 11'(PADDLE_R_X)) &&
                   (ball_bottom > {1'b0, r_pr}) && ({1'b0, r_y} < pr_bottom);
    hit_wall     = (r_y == 10'd0) || (ball_bottom >= 11'(SCREEN_Y));
  end

  state_e     state_q, state_d;
  bounce_e    code_q, code_d;
  bounce_e    bounce;
  logic [9:0] snap_x, snap_y;
  logic [3:0] score_l_q, score_r_q;
  logic       snap_en, inc_l, inc_r, moved, at_max, over;
`ifdef SERVE_PAUSE_EN
  logic [10:0] serve_cnt;
`endif

  assign moved  = (r_x != snap_x) || (r_y != snap_y);
  assign at_max = (score_l_q == SCORE_TOP) || (score_r_q == SCORE_TOP);

  // NOTE: every signal written here gets a default first; a path that skips
  // an assignment would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    snap_en = 1'b0;
    inc_l   = 1'b0;
    inc_r   = 1'b0;
    bounce  = B_NONE;
    over    = 1'b0;
    unique case (state_q)
      TRACK: begin
        if (r_valid) begin
          // Priority: score, then paddle (wins corners), then wall.
          if (hit_score_r || hit_score_l) begin
            inc_r  = hit_score_r;
            inc_l  = !hit_score_r;
            code_d = B_SCORE;
          end else if (hit_paddle_l || hit_paddle_r) begin
            code_d = B_PADDLE;
          end else if (hit_wall) begin
            code_d = B_WALL;
          end
          if (hit_score_r || hit_score_l || hit_paddle_l || hit_paddle_r || hit_wall) begin
            snap_en = 1'b1;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        bounce = code_q;
        if (moved) begin
          if (code_q != B_SCORE) begin
            state_d = TRACK;
          end else if (at_max) begin
            state_d = GAME_OVER;
          end else begin
`ifdef SERVE_PAUSE_EN
            state_d = SERVE;
`else
            state_d = TRACK;
`endif
          end
        end
      end
      GAME_OVER: begin
        bounce = B_SCORE;
        over   = 1'b1;
      end
`ifdef SERVE_PAUSE_EN
      SERVE: begin
        bounce = B_SCORE;
        if (serve_cnt == 11'(SERVE_DELAY - 1)) state_d = TRACK;
      end
`endif
      default: state_d = TRACK;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= TRACK;
      code_q    <= B_NONE;
      snap_x    <= '0;
      snap_y    <= '0;
      score_l_q <= '0;
      score_r_q <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      if (snap_en) begin
        snap_x <= r_x;
        snap_y <= r_y;
      end
      // Increments fire only on the TRACK->HOLD edge, so once per point.
      if (inc_l && score_l_q != SCORE_TOP) score_l_q <= score_l_q + 4'd1;
      if (inc_r && score_r_q != SCORE_TOP) score_r_q <= score_r_q + 4'd1;
    end
  end

`ifdef SERVE_PAUSE_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                serve_cnt <= '0;
    else if (state_q != SERVE) serve_cnt <= '0;
    else                       serve_cnt <= serve_cnt + 11'd1;
  end
`endif

  assign bus.bounce    = bounce;
  assign bus.score_l   = score_l_q;
  assign bus.score_r   = score_r_q;
  assign bus.game_over = over;

endmodule

// File: tb/tb_ball_collision.sv
// Scoreboard bench for ball_collision: directed plan followed by biased
// random geometry, compared against a rule-level reference model.
module tb_ball_collision;
  localparam int SX = 640, SY = 480, PLX = 16, PRX = 618, PW = 6, PH = 48;
  localparam int SMAX = 9, SDELAY = 1000;
  localparam int M_TRACK = 0, M_HOLD = 1, M_OVER = 2, M_SERVE = 3;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  ball_collision_if bus();
  ball_collision dut (.clock(clock), .reset(reset), .bus(bus));

  typedef struct packed {
    logic [1:0] bounce;
    logic [3:0] sl;
    logic [3:0] sr;
    logic       go;
  } obs_t;

  obs_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: previous-cycle geometry plus game situation.
  int m_rv, m_rx, m_ry, m_rw, m_rh, m_rpl, m_rpr;
  int m_mode, m_code, m_sx, m_sy, m_sl, m_sr, m_left;

  task automatic check(input string name, input obs_t act, input obs_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got bounce=%b sl=%0d sr=%0d go=%b, want bounce=%b sl=%0d sr=%0d go=%b",
               name, $time, act.bounce, act.sl, act.sr, act.go,
               exp.bounce, exp.sl, exp.sr, exp.go);
    end
  endtask

  function automatic obs_t dut_obs();
    return {bus.bounce, bus.score_l, bus.score_r, bus.game_over};
  endfunction

  function automatic bit overlaps(input int py);
    return (m_ry + m_rh > py) && (m_ry < py + PH);
  endfunction

  // Bounce code the rules call for on the seen geometry (0 = nothing).
  function automatic int rule_code();
    if (m_rx == 0 || m_rx + m_rw >= SX) return 3;
    if ((m_rx == PLX + PW && overlaps(m_rpl)) || (m_rx + m_rw == PRX && overlaps(m_rpr))) return 1;
    if (m_ry == 0 || m_ry + m_rh >= SY) return 2;
    return 0;
  endfunction

  task automatic model_clear();
    {m_rv, m_rx, m_ry, m_rw, m_rh, m_rpl, m_rpr} = '0;
    {m_mode, m_code, m_sx, m_sy, m_sl, m_sr, m_left} = '0;
  endtask

  task automatic model_edge();
    int c;
    if (!reset) begin
      model_clear();
      return;
    end
    if (m_mode == M_TRACK && m_rv != 0) begin
      c = rule_code();
      if (c != 0) begin
        m_code = c;
        m_sx   = m_rx;
        m_sy   = m_ry;
        m_mode = M_HOLD;
        if (c == 3 && m_rx == 0)  m_sr = (m_sr < SMAX) ? m_sr + 1 : SMAX;
        else if (c == 3)          m_sl = (m_sl < SMAX) ? m_sl + 1 : SMAX;
      end
    end else if (m_mode == M_HOLD && (m_rx != m_sx || m_ry != m_sy)) begin
      if (m_code != 3)                       m_mode = M_TRACK;
      else if (m_sl == SMAX || m_sr == SMAX) m_mode = M_OVER;
      else begin
`ifdef SERVE_PAUSE_EN
        m_mode = M_SERVE;
        m_left = SDELAY;
`else
        m_mode = M_TRACK;
`endif
      end
    end else if (m_mode == M_SERVE) begin
      m_left--;
      if (m_left == 0) m_mode = M_TRACK;
    end
    m_rx  = int'(bus.ball_x);
    m_ry  = int'(bus.ball_y);
    m_rw  = int'(bus.ball_w);
    m_rh  = int'(bus.ball_h);
    m_rpl = int'(bus.paddle_l_y);
    m_rpr = int'(bus.paddle_r_y);
    m_rv  = 1;
  endtask

  function automatic obs_t model_obs();
    obs_t o;
    o.bounce = (m_mode == M_TRACK) ? 2'b00 : (m_mode == M_HOLD) ? 2'(m_code) : 2'b11;
    o.sl     = 4'(m_sl);
    o.sr     = 4'(m_sr);
    o.go     = (m_mode == M_OVER);
    return o;
  endfunction

  // Drive one geometry for n clocks; inputs change just after the falling edge.
  task automatic drive(input int x, input int y, input int w, input int h,
                       input int pl, input int pr, input int n);
    bus.ball_x     = 10'(x);
    bus.ball_y     = 10'(y);
    bus.ball_w     = 8'(w);
    bus.ball_h     = 8'(h);
    bus.paddle_l_y = 10'(pl);
    bus.paddle_r_y = 10'(pr);
    repeat (n) begin
      @(posedge clock);
      model_edge();
      exp_q.push_back(model_obs());
      @(negedge clock);
      #1;
    end
  endtask

  // Mid-run reset: outputs must clear before any clock edge.
  task automatic pulse_reset();
    reset = 1'b0;
    #1;
    check("async_reset", dut_obs(), '0);
    drive(320, 240, 6, 6, 200, 200, 2);
    reset = 1'b1;
  endtask

  always @(negedge clock) begin
    if (exp_q.size() > 0) check("scoreboard", dut_obs(), exp_q.pop_front());
  end

  initial begin
    int x, y, w, h, pl, pr;
    model_clear();

    // Reset with ball parked on the left goal line, then release.
    drive(0, 100, 6, 6, 0, 0, 3);
    reset = 1'b1;
    drive(0, 100, 6, 6, 0, 0, 4);

    // Top wall held static, then a small move releases it.
    drive(320, 0, 6, 6, 0, 0, 100);
    drive(321, 1, 6, 6, 0, 0, 6);

    // Left paddle face: overlap, then just below the paddle.
    drive(22, 210, 6, 6, 200, 0, 5);
    drive(300, 210, 6, 6, 200, 0, 3);
    drive(22, 248, 6, 6, 200, 0, 5);

    // Corner (paddle + wall) and right paddle face.
    drive(22, 0, 6, 6, 0, 0, 5);
    drive(300, 200, 6, 6, 0, 0, 3);
    drive(612, 300, 6, 6, 0, 280, 5);

    // Right player scores once despite a long hold; centre the ball.
    drive(0, 100, 6, 6, 0, 0, 50);
    drive(321, 241, 6, 6, 0, 0, 5 + ((m_mode == M_SERVE) ? SDELAY : 0));

    // Bring score_r to 8, then score the winning point (also left-goal checks).
    drive(634, 100, 6, 6, 0, 0, 4);
    drive(320, 240, 6, 6, 0, 0, 4 + ((m_mode == M_SERVE) ? SDELAY : 0));
    while (m_sr < SMAX - 1) begin
      drive(0, 100, 6, 6, 0, 0, 3);
      drive(320, 240, 6, 6, 0, 0, 4 + ((m_mode == M_SERVE) ? SDELAY : 0));
    end
    drive(0, 50, 6, 6, 0, 0, 4);
    drive(320, 240, 6, 6, 0, 0, 4);
    drive(100, 300, 6, 6, 0, 0, 4);
    drive(22, 0, 6, 6, 0, 0, 4);
    pulse_reset();

    // Biased random geometry with occasional resets.
    for (int v = 0; v < 400; v++) begin
      w  = int'($urandom_range(1, 16));
      h  = int'($urandom_range(1, 16));
      pl = int'($urandom_range(0, SY - PH));
      pr = int'($urandom_range(0, SY - PH));
      case ($urandom_range(0, 5))
        0:       x = 0;
        1:       x = PLX + PW;
        2:       x = PRX - w;
        3:       x = SX - w + int'($urandom_range(0, 3));
        4:       x = int'($urandom_range(1, SX - 20));
        default: x = 320;
      endcase
      case ($urandom_range(0, 3))
        0:       y = 0;
        1:       y = SY - h;
        2:       y = ((x < SX / 2) ? pl : pr) + int'($urandom_range(0, PH + 16)) - h;
        default: y = int'($urandom_range(1, SY - 20));
      endcase
      if (y < 0) y = 0;
      if (y > SY) y = SY;
      drive(x, y, w, h, pl, pr, int'($urandom_range(1, 4)));
      if ($urandom_range(0, 39) == 0) pulse_reset();
    end

    repeat (10) begin
      if (exp_q.size() == 0) break;
      @(negedge clock);
      #1;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expected outputs never compared, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
